// File: rtl/svcs_trnx_sched.sv
// svcs_trnx_sched: round-robin scheduler that splits requester arrays into header+payload chunks on one outbound stream.
// Optional macro SVCS_SCHED_CHUNK_SEQ_EN adds a per-array chunk sequence number to header bits [31:16].
module svcs_trnx_sched #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 64,
  parameter int LEN_W     = 16,
  parameter int MAX_CHUNK = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*8-1:0]      req_type,
  input  logic [NUM_REQ*16-1:0]     req_id,
  input  logic [NUM_REQ*8-1:0]      req_dtype,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  input  logic [NUM_REQ*DATA_W-1:0] src_data,
  input  logic [NUM_REQ-1:0]        src_valid,
  output logic [NUM_REQ-1:0]        src_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_is_hdr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_REQ-1:0]        done,
  output logic                      busy
);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [LEN_W-1:0] MAXC = LEN_W'(MAX_CHUNK);
  typedef enum logic [1:0] {IDLE, HDR, PAY, DONE} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] g_q, g_d, rr_q, rr_d, gsel;
  logic found;
  logic [7:0] type_q, type_d, dtype_q, dtype_d;
  logic [15:0] id_q, id_d, seq_hdr;
  logic [LEN_W-1:0] rem_q, rem_d, chunk_q, chunk_d, beat_q, beat_d, rem_next;
`ifdef SVCS_SCHED_CHUNK_SEQ_EN
  logic [15:0] seq_q, seq_d;
  assign seq_hdr = seq_q;
`else
  assign seq_hdr = '0;
`endif

  function automatic logic [LEN_W-1:0] min_chunk(input logic [LEN_W-1:0] r);
    return (r < MAXC) ? r : MAXC;
  endfunction

  // round-robin pick: descending scan so the lowest offset from rr wins
  always_comb begin
    found = 1'b0;
    gsel  = rr_q;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[(int'(rr_q) + i) % NUM_REQ]) begin
        found = 1'b1;
        gsel  = IW'((int'(rr_q) + i) % NUM_REQ);
      end
    end
  end

  // next-state and outputs; req_ready is gated by rst_n so reset forces it low
  always_comb begin
    state_d    = state_q;
    g_d        = g_q;
    rr_d       = rr_q;
    type_d     = type_q;
    id_d       = id_q;
    dtype_d    = dtype_q;
    rem_d      = rem_q;
    chunk_d    = chunk_q;
    beat_d     = beat_q;
`ifdef SVCS_SCHED_CHUNK_SEQ_EN
    seq_d      = seq_q;
`endif
    req_ready  = '0;
    src_ready  = '0;
    out_valid  = 1'b0;
    out_is_hdr = 1'b0;
    out_data   = '0;
    done       = '0;
    busy       = (state_q != IDLE);
    rem_next   = rem_q - chunk_q;
    case (state_q)
      IDLE: if (found) begin
        g_d            = gsel;
        type_d         = req_type[gsel*8 +: 8];
        id_d           = req_id[gsel*16 +: 16];
        dtype_d        = req_dtype[gsel*8 +: 8];
        rem_d          = req_len[gsel*LEN_W +: LEN_W];
        chunk_d        = min_chunk(req_len[gsel*LEN_W +: LEN_W]);
`ifdef SVCS_SCHED_CHUNK_SEQ_EN
        seq_d          = '0;
`endif
        req_ready[gsel] = rst_n;
        state_d        = HDR;
      end
      HDR: begin
        out_valid      = 1'b1;
        out_is_hdr     = 1'b1;
        out_data[63:0] = {type_q, id_q, dtype_q, seq_hdr, 16'(chunk_q)};
        if (out_ready) begin
          beat_d  = chunk_q;
          state_d = (chunk_q == '0) ? DONE : PAY;
        end
      end
      PAY: begin
        out_valid      = src_valid[g_q];
        src_ready[g_q] = out_ready;
        out_data       = src_data[g_q*DATA_W +: DATA_W];
        if (src_valid[g_q] && out_ready) begin
          beat_d = beat_q - 1'b1;
          if (beat_q == LEN_W'(1)) begin
            rem_d   = rem_next;
            chunk_d = min_chunk(rem_next);
`ifdef SVCS_SCHED_CHUNK_SEQ_EN
            seq_d   = seq_q + 16'd1;
`endif
            state_d = (rem_next == '0) ? DONE : HDR;
          end
        end
      end
      DONE: begin
        done[g_q] = 1'b1;
        rr_d      = (g_q == IW'(NUM_REQ - 1)) ? '0 : g_q + 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state registers; async reset abandons any transfer and returns rr to 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      g_q     <= '0;
      rr_q    <= '0;
      type_q  <= '0;
      id_q    <= '0;
      dtype_q <= '0;
      rem_q   <= '0;
      chunk_q <= '0;
      beat_q  <= '0;
`ifdef SVCS_SCHED_CHUNK_SEQ_EN
      seq_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      rr_q    <= rr_d;
      type_q  <= type_d;
      id_q    <= id_d;
      dtype_q <= dtype_d;
      rem_q   <= rem_d;
      chunk_q <= chunk_d;
      beat_q  <= beat_d;
`ifdef SVCS_SCHED_CHUNK_SEQ_EN
      seq_q   <= seq_d;
`endif
    end
  end
endmodule

// File: tb/tb_svcs_trnx_sched.sv
// tb_svcs_trnx_sched: directed table and sequence checks of svcs_trnx_sched against a reference beat model.
module tb_svcs_trnx_sched;
  localparam int N = 4, DW = 64, LW = 16, MC = 16;
`ifdef SVCS_SCHED_CHUNK_SEQ_EN
  localparam bit SEQ = 1'b1;
`else
  localparam bit SEQ = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req_valid, req_ready, src_valid, src_ready, done;
  logic [N*8-1:0] req_type, req_dtype;
  logic [N*16-1:0] req_id;
  logic [N*LW-1:0] req_len;
  logic [N*DW-1:0] src_data;
  logic [DW-1:0] out_data;
  logic out_is_hdr, out_valid, out_ready, busy;

  svcs_trnx_sched #(.NUM_REQ(N), .DATA_W(DW), .LEN_W(LW), .MAX_CHUNK(MC)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_type(req_type), .req_id(req_id), .req_dtype(req_dtype), .req_len(req_len),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .out_data(out_data), .out_is_hdr(out_is_hdr), .out_valid(out_valid), .out_ready(out_ready),
    .done(done), .busy(busy));

  always #5 clk = ~clk;

  typedef struct {logic hdr; logic [DW-1:0] data;} beat_t;
  typedef struct {int r; int len; logic [7:0] t; logic [15:0] id; logic [7:0] dt; int hdrs; int lat;} vec_t;
  beat_t got_q[$], exp_q[$];
  int dones[$], accs[$];
  int done_cyc, acc_cyc, cyc, vecs, errs;
  int cnt[N], exp_cnt[N];
  logic stall_en, gap_en, prev_stall, prev_hdr;
  logic [DW-1:0] prev_data;
  logic [N-1:0] src_seen;
  vec_t tbl[5];
  int ord[4];

  task automatic chk(string name, logic [71:0] act, logic [71:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic drive_src();
    for (int r = 0; r < N; r++) src_data[r*DW +: DW] = {8'(r), 56'(cnt[r])};
  endtask

  task automatic step();
    logic [N-1:0] hs, acc;
    @(negedge clk);
    hs  = src_valid & src_ready;
    acc = req_ready;
    if (prev_stall && (prev_hdr || out_valid)) begin
      chk("stall_data", {8'd0, out_data}, {8'd0, prev_data});
      chk("stall_kind", {71'd0, out_is_hdr}, {71'd0, prev_hdr});
      if (prev_hdr) chk("hdr_valid_held", {71'd0, out_valid}, 72'd1);
    end
    prev_stall = rst_n && out_valid && !out_ready;
    prev_hdr   = out_is_hdr;
    prev_data  = out_data;
    if (out_valid && out_ready) got_q.push_back('{out_is_hdr, out_data});
    for (int r = 0; r < N; r++) begin
      if (done[r]) begin dones.push_back(r); done_cyc = cyc; end
      if (acc[r]) begin accs.push_back(r); acc_cyc = cyc; end
    end
    src_seen |= src_ready;
    @(posedge clk);
    #1;
    cyc++;
    for (int r = 0; r < N; r++) cnt[r] = !rst_n ? 0 : cnt[r] + int'(hs[r]);
    req_valid &= ~acc;
    out_ready = !(stall_en && (cyc % 2 == 1));
    src_valid = (gap_en && (cyc % 3 == 2)) ? '0 : '1;
    drive_src();
  endtask

  task automatic run(int n, int budget);
    int k = 0;
    while (dones.size() < n && k < budget) begin step(); k++; end
    chk("run_dones", 72'(dones.size()), 72'(n));
  endtask

  task automatic clear();
    got_q.delete(); exp_q.delete(); dones.delete(); accs.delete(); src_seen = '0;
  endtask

  task automatic set_req(int r, int len, logic [7:0] t, logic [15:0] id, logic [7:0] dt);
    req_type[r*8 +: 8]   = t;
    req_id[r*16 +: 16]   = id;
    req_dtype[r*8 +: 8]  = dt;
    req_len[r*LW +: LW]  = LW'(len);
    req_valid[r]         = 1'b1;
  endtask

  task automatic model(int r, int len, logic [7:0] t, logic [15:0] id, logic [7:0] dt);
    int rem = len, seq = 0, c;
    do begin
      c = (rem < MC) ? rem : MC;
      exp_q.push_back('{1'b1, {t, id, dt, SEQ ? 16'(seq) : 16'h0, 16'(c)}});
      for (int k = 0; k < c; k++) begin
        exp_q.push_back('{1'b0, {8'(r), 56'(exp_cnt[r])}});
        exp_cnt[r]++;
      end
      rem -= c;
      seq++;
    end while (rem > 0);
  endtask

  task automatic cmp_stream(string name);
    chk({name, "_beats"}, 72'(got_q.size()), 72'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk(name, {7'd0, got_q[i].hdr, got_q[i].data}, {7'd0, exp_q[i].hdr, exp_q[i].data});
  endtask

  task automatic rr_burst(string name);
    clear();
    for (int r = 0; r < N; r++) set_req(r, 1, 8'(r + 16), 16'(r * 257), 8'(r + 1));
    for (int i = 0; i < 4; i++) model(ord[i], 1, 8'(ord[i] + 16), 16'(ord[i] * 257), 8'(ord[i] + 1));
    run(4, 100);
    for (int i = 0; i < 4 && i < accs.size(); i++) chk(name, 72'(accs[i]), 72'(ord[i]));
    cmp_stream({name, "_stream"});
  endtask

  initial begin
    int h, k;
    tbl[0] = '{0, 5,  8'hA1, 16'h1001, 8'h11, 1, 7};
    tbl[1] = '{1, 40, 8'hB2, 16'h2002, 8'h22, 3, 44};
    tbl[2] = '{2, 0,  8'hC3, 16'h3003, 8'h33, 1, 2};
    tbl[3] = '{3, 16, 8'hD4, 16'h4004, 8'h44, 1, 18};
    tbl[4] = '{3, 17, 8'hE5, 16'h5005, 8'h55, 2, 20};
    cyc = 0; vecs = 0; errs = 0; stall_en = 0; gap_en = 0; prev_stall = 0; prev_hdr = 0; prev_data = '0;
    for (int r = 0; r < N; r++) begin cnt[r] = 0; exp_cnt[r] = 0; end
    req_valid = '1; req_type = '0; req_id = '0; req_dtype = '0; req_len = '0;
    out_ready = 1'b1; src_valid = '1; drive_src();
    #12;
    chk("reset_ctl", {59'd0, out_valid, out_is_hdr, busy, req_ready, src_ready, done}, 72'd0);
    chk("reset_data", {8'd0, out_data}, 72'd0);
    @(posedge clk); #1;
    req_valid = '0;
    rst_n = 1'b1;
    step();
    chk("idle_busy", {71'd0, busy}, 72'd0);

    for (int i = 0; i < 5; i++) begin
      clear();
      set_req(tbl[i].r, tbl[i].len, tbl[i].t, tbl[i].id, tbl[i].dt);
      model(tbl[i].r, tbl[i].len, tbl[i].t, tbl[i].id, tbl[i].dt);
      run(1, 200);
      cmp_stream("tbl_stream");
      chk("tbl_done_idx", 72'(dones.size() > 0 ? dones[0] : -1), 72'(tbl[i].r));
      chk("tbl_latency", 72'(done_cyc - acc_cyc), 72'(tbl[i].lat));
      h = 0;
      foreach (got_q[j]) h += int'(got_q[j].hdr);
      chk("tbl_hdrs", 72'(h), 72'(tbl[i].hdrs));
      chk("tbl_src_ready", 72'(src_seen), 72'(tbl[i].len > 0 ? (1 << tbl[i].r) : 0));
    end

    ord = '{0, 1, 2, 3};
    rr_burst("rr_order_a");
    rr_burst("rr_order_b");
    clear();
    set_req(1, 2, 8'h61, 16'h0611, 8'h16);
    model(1, 2, 8'h61, 16'h0611, 8'h16);
    run(1, 50);
    cmp_stream("rr_single");
    ord = '{2, 3, 0, 1};
    rr_burst("rr_wrap");

    stall_en = 1'b1; gap_en = 1'b1;
    clear();
    set_req(1, 20, 8'h77, 16'h7707, 8'h07);
    model(1, 20, 8'h77, 16'h7707, 8'h07);
    run(1, 400);
    cmp_stream("stall_stream");
    stall_en = 1'b0; gap_en = 1'b0;
    step();

    clear();
    set_req(0, 40, 8'h88, 16'h8808, 8'h08);
    k = 0;
    while (got_q.size() < 21 && k < 100) begin step(); k++; end
    chk("mid_pay_reached", 72'(got_q.size() >= 21), 72'd1);
    clear();
    req_valid = '1;
    #2 rst_n = 1'b0;
    prev_stall = 1'b0;
    #1;
    chk("async_rst_ctl", {59'd0, out_valid, out_is_hdr, busy, req_ready, src_ready, done}, 72'd0);
    chk("async_rst_data", {8'd0, out_data}, 72'd0);
    req_valid = '0;
    repeat (3) step();
    chk("rst_no_done", 72'(dones.size()), 72'd0);
    for (int r = 0; r < N; r++) exp_cnt[r] = 0;
    rst_n = 1'b1;
    clear();
    set_req(1, 2, 8'h91, 16'h9101, 8'h19);
    set_req(3, 2, 8'h93, 16'h9303, 8'h39);
    model(1, 2, 8'h91, 16'h9101, 8'h19);
    model(3, 2, 8'h93, 16'h9303, 8'h39);
    run(2, 100);
    chk("post_rst_first", 72'(accs.size() > 0 ? accs[0] : -1), 72'd1);
    chk("post_rst_second", 72'(accs.size() > 1 ? accs[1] : -1), 72'd3);
    cmp_stream("post_rst_stream");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
